sao_db_sequencer: RTL and testbench

//  Per-LCU sequencer for the deblocking/SAO stage. Drives the shared 3-bit state
//  bus and 9-bit cycle counter consumed by the DB filters and the SAO BO

---
 rtl/sao_db_sequencer_pkg.sv | 34 +++
 rtl/sao_db_sequencer.sv | 135 +++++++++++++
 tb/tb_sao_db_sequencer.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/sao_db_sequencer_pkg.sv
// State encodings and counter sizing shared by the DB filters, SAO BO predecision and the LCU sequencer.
// No logic of its own; the consumers decode state_t directly off the shared state bus.
package sao_db_sequencer_pkg;

  localparam int CNT_W   = 9;
  localparam int CNT_MAX = 1 << CNT_W;

  localparam int DEF_LOAD_CYC = 128;
  localparam int DEF_Y_CYC    = 128;
  localparam int DEF_U_CYC    = 32;
  localparam int DEF_V_CYC    = 32;
  localparam int DEF_SAO_CYC  = 64;
  localparam int DEF_OUT_CYC  = 64;

  // SAO cycle on which the BO predecision result is valid: DBV's final
  // accumulate is followed by the first_bo stage and then the output register.
  localparam int BO_VLD_CNT = 2;

  // Gray-like walk so adjacent phases differ by one bit on the shared bus.
  typedef enum logic [2:0] {
    ST_IDLE = 3'b000,
    ST_LOAD = 3'b001,
    ST_DBY  = 3'b011,
    ST_DBU  = 3'b010,
    ST_DBV  = 3'b110,
    ST_SAO  = 3'b100,
    ST_OUT  = 3'b101
  } state_t;

  function automatic logic is_db_state(input state_t st);
    return (st == ST_DBY) || (st == ST_DBU) || (st == ST_DBV);
  endfunction

endpackage

// File: rtl/sao_db_sequencer.sv
// Per-LCU DB/SAO sequencer: walks LOAD->DBY->DBU->DBV->SAO->OUT; all outputs registered, 448 cycles/LCU stall-free.
// Backpressure: DB phases advance only on blk_vld_i while blk_rdy_o is high; blk_vld_i low holds state and count.
module sao_db_sequencer
  import sao_db_sequencer_pkg::*;
#(
  parameter int LOAD_CYC = DEF_LOAD_CYC,
  parameter int Y_CYC    = DEF_Y_CYC,
  parameter int U_CYC    = DEF_U_CYC,
  parameter int V_CYC    = DEF_V_CYC,
  parameter int SAO_CYC  = DEF_SAO_CYC,
  parameter int OUT_CYC  = DEF_OUT_CYC
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             blk_vld_i,
  output logic             blk_rdy_o,
  output logic [2:0]       state_o,
  output logic [CNT_W-1:0] cnt_o,
  output logic             bo_vld_o,
  output logic             busy_o,
  output logic             done_o
);

  if (LOAD_CYC < 1 || LOAD_CYC > CNT_MAX) begin : g_bad_load
    $error("LOAD_CYC out of range 1..512");
  end
  if (Y_CYC < 1 || Y_CYC > CNT_MAX) begin : g_bad_y
    $error("Y_CYC out of range 1..512");
  end
  if (U_CYC < 1 || U_CYC > CNT_MAX) begin : g_bad_u
    $error("U_CYC out of range 1..512");
  end
  if (V_CYC < 1 || V_CYC > CNT_MAX) begin : g_bad_v
    $error("V_CYC out of range 1..512");
  end
  if (SAO_CYC < BO_VLD_CNT + 1 || SAO_CYC > CNT_MAX) begin : g_bad_sao
    $error("SAO_CYC out of range 3..512");
  end
  if (OUT_CYC < 1 || OUT_CYC > CNT_MAX) begin : g_bad_out
    $error("OUT_CYC out of range 1..512");
  end

  localparam logic [CNT_W-1:0] LOAD_LAST = CNT_W'(LOAD_CYC - 1);
  localparam logic [CNT_W-1:0] Y_LAST    = CNT_W'(Y_CYC - 1);
  localparam logic [CNT_W-1:0] U_LAST    = CNT_W'(U_CYC - 1);
  localparam logic [CNT_W-1:0] V_LAST    = CNT_W'(V_CYC - 1);
  localparam logic [CNT_W-1:0] SAO_LAST  = CNT_W'(SAO_CYC - 1);
  localparam logic [CNT_W-1:0] OUT_LAST  = CNT_W'(OUT_CYC - 1);
  localparam logic [CNT_W-1:0] BO_CNT    = CNT_W'(BO_VLD_CNT);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] last_cnt;
  logic             is_db, advance, last_beat;
  logic             blk_rdy_q, bo_vld_q, busy_q, done_q;

  always_comb begin
    last_cnt  = '0;
    state_d   = state_q;
    is_db     = is_db_state(state_q);
    advance   = !is_db || blk_vld_i;

    case (state_q)
      ST_LOAD: last_cnt = LOAD_LAST;
      ST_DBY:  last_cnt = Y_LAST;
      ST_DBU:  last_cnt = U_LAST;
      ST_DBV:  last_cnt = V_LAST;
      ST_SAO:  last_cnt = SAO_LAST;
      ST_OUT:  last_cnt = OUT_LAST;
      default: last_cnt = '0;
    endcase

    last_beat = (cnt_q == last_cnt) && advance;

    case (state_q)
      ST_IDLE: if (start_i)   state_d = ST_LOAD;
      ST_LOAD: if (last_beat) state_d = ST_DBY;
      ST_DBY:  if (last_beat) state_d = ST_DBU;
      ST_DBU:  if (last_beat) state_d = ST_DBV;
      ST_DBV:  if (last_beat) state_d = ST_SAO;
      ST_SAO:  if (last_beat) state_d = ST_OUT;
      ST_OUT:  if (last_beat) state_d = ST_IDLE;
      default:                state_d = ST_IDLE;
    endcase

    // IDLE and the unused encoding both pin the counter at zero.
    if (state_q == ST_IDLE || state_d == ST_IDLE || last_beat) begin
      cnt_d = '0;
    end else if (advance) begin
      cnt_d = cnt_q + 1'b1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Flags are computed from the next state so they line up with state_o/cnt_o.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blk_rdy_q <= 1'b0;
      bo_vld_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      blk_rdy_q <= is_db_state(state_d);
      bo_vld_q  <= (state_d == ST_SAO) && (cnt_d == BO_CNT);
      busy_q    <= (state_d != ST_IDLE);
      done_q    <= (state_d == ST_OUT) && (cnt_d == OUT_LAST);
    end
  end

  assign state_o   = state_q;
  assign cnt_o     = cnt_q;
  assign blk_rdy_o = blk_rdy_q;
  assign bo_vld_o  = bo_vld_q;
  assign busy_o    = busy_q;
  assign done_o    = done_q;

endmodule

// File: tb/tb_sao_db_sequencer.sv
// Directed bench for sao_db_sequencer: full LCUs, DBY stall, ignored starts, back-to-back and mid-LCU reset.
module tb_sao_db_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start_i = 1'b0;
  logic       blk_vld_i = 1'b1;
  logic       blk_rdy_o;
  logic [2:0] state_o;
  logic [8:0] cnt_o;
  logic       bo_vld_o, busy_o, done_o;

  int checks = 0;
  int errors = 0;

  sao_db_sequencer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start_i   (start_i),
    .blk_vld_i (blk_vld_i),
    .blk_rdy_o (blk_rdy_o),
    .state_o   (state_o),
    .cnt_o     (cnt_o),
    .bo_vld_o  (bo_vld_o),
    .busy_o    (busy_o),
    .done_o    (done_o)
  );

  always #5 clk = ~clk;

  // Hand-written LCU schedule: state code and length of each phase.
  logic [2:0] seg_st  [6] = '{3'b001, 3'b011, 3'b010, 3'b110, 3'b100, 3'b101};
  int         seg_len [6] = '{128, 128, 32, 32, 64, 64};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Called at a negedge with the DUT idle; pulses start_i and tracks one LCU
  // against the schedule, returning on the IDLE cycle right after done_o.
  task automatic run_lcu(input string tag, input int stall_len, input bit inject);
    int seg = 0, idx = 0, stall_left = 0, mism = 0, dones = 0, bos = 0, done_at = 0;
    bit stalled = 1'b0;
    logic [2:0] e_st;
    logic [8:0] e_cnt;
    start_i = 1'b1;
    blk_vld_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    for (int k = 1; k <= 700; k++) begin
      e_st  = (seg < 6) ? seg_st[seg] : 3'b000;
      e_cnt = (seg < 6) ? 9'(idx) : 9'd0;
      if (state_o !== e_st || cnt_o !== e_cnt) mism++;
      if (busy_o !== (seg < 6)) mism++;
      if (blk_rdy_o !== (seg >= 1 && seg <= 3)) mism++;
      if (bo_vld_o !== (seg == 4 && idx == 2)) mism++;
      if (done_o !== (seg == 5 && idx == seg_len[5] - 1)) mism++;
      if (done_o === 1'b1) begin dones++; done_at = k; end
      if (bo_vld_o === 1'b1) bos++;
      if (seg == 6) break;
      start_i = inject && ((seg == 2 && idx == 5) || (seg == 5 && idx == 10));
      if (stall_len > 0 && seg == 1 && idx == 50 && !stalled) begin
        stall_left = stall_len;
        stalled = 1'b1;
      end
      blk_vld_i = (stall_left == 0);
      if (stall_left > 0) begin
        stall_left--;
      end else begin
        idx++;
        if (idx == seg_len[seg]) begin seg++; idx = 0; end
      end
      @(negedge clk);
    end
    start_i = 1'b0;
    blk_vld_i = 1'b1;
    chk({tag, "_reached_idle"}, seg, 6);
    chk({tag, "_cycle_mismatches"}, mism, 0);
    chk({tag, "_done_pulses"}, dones, 1);
    chk({tag, "_done_cycle"}, done_at, 448 + stall_len);
    chk({tag, "_bo_pulses"}, bos, 1);
  endtask

  initial begin
    int mism;
    int dones;
    bit hit;

    // 1: reset and idle
    #12;
    chk("rst_state", state_o, 3'b000);
    chk("rst_cnt", cnt_o, 0);
    @(negedge clk);
    rst_n = 1'b1;
    mism = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (state_o !== 3'b000 || cnt_o !== 9'd0) mism++;
      if (blk_rdy_o !== 1'b0 || bo_vld_o !== 1'b0 || busy_o !== 1'b0 || done_o !== 1'b0) mism++;
    end
    chk("idle_outputs", mism, 0);
    chk("idle_busy", busy_o, 0);

    // 2: clean LCU
    run_lcu("clean", 0, 1'b0);

    // 3: DBY stall of 7 cycles at cnt 50
    @(negedge clk);
    run_lcu("stall", 7, 1'b0);

    // 5: ignored starts in DBU and OUT, then back-to-back start right after done
    @(negedge clk);
    run_lcu("ignored_start", 0, 1'b1);
    run_lcu("back_to_back", 0, 1'b0);

    // 6: async reset during DBV cnt 10
    @(negedge clk);
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if (state_o === 3'b110 && cnt_o === 9'd10) begin hit = 1'b1; break; end
      @(negedge clk);
    end
    chk("reach_dbv10", hit, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_state", state_o, 3'b000);
    chk("arst_cnt", cnt_o, 0);
    chk("arst_busy", busy_o, 0);
    chk("arst_rdy", blk_rdy_o, 0);
    dones = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (done_o === 1'b1) dones++;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (done_o === 1'b1) dones++;
    end
    chk("arst_no_done", dones, 0);
    chk("arst_idle_held", state_o, 3'b000);
    run_lcu("after_reset", 0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
